// File: rtl/mem_reinit_pkg.sv
// Shared types and constants for the BRAM readback streamer.
package mem_reinit_pkg;

  localparam int unsigned RB_BUF_DEPTH = 4;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StFlush
  } rb_state_e;

endpackage

// File: rtl/rb_fifo.sv
// Small synchronous FIFO holding readback words plus their last flag.
module rb_fifo
  import mem_reinit_pkg::*;
#(
  parameter int unsigned Width = 19,
  parameter int unsigned Depth = RB_BUF_DEPTH,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic [CntW-1:0]  count_o,
  output logic             empty_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    if (ptr == PtrW'(Depth - 1)) begin
      return '0;
    end
    return ptr + PtrW'(1);
  endfunction

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_i) begin
      wptr_d = ptr_inc(wptr_q);
    end
    if (pop_i) begin
      rptr_d = ptr_inc(rptr_q);
    end
    count_d = count_q + CntW'(push_i) - CntW'(pop_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the count gates every observable read.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/mem_readback_streamer.sv
// Sweeps a BRAM read port from address 0 to DEPTH_MEM-1 and streams each word
// out on a valid/ready interface with a last flag and running XOR checksum.
module mem_readback_streamer
  import mem_reinit_pkg::*;
#(
  parameter int unsigned WID_MEM   = 18,
  parameter int unsigned DEPTH_MEM = 4096,
  parameter int unsigned ADDR_W    = 12
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  output logic [ADDR_W-1:0]  raddr_o,
  input  logic [WID_MEM-1:0] rdata_i,
  output logic               m_valid_o,
  input  logic               m_ready_i,
  output logic [WID_MEM-1:0] m_data_o,
  output logic               m_last_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [WID_MEM-1:0] checksum_o
);

  localparam int unsigned       CntW     = $clog2(RB_BUF_DEPTH + 1);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH_MEM - 1);

  rb_state_e          state_q, state_d;
  logic [ADDR_W-1:0]  raddr_q, raddr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WID_MEM-1:0] chk_q, chk_d;
  logic               inflight_q, inflight_d;
  logic               inflight_last_q, inflight_last_d;

  logic               issue;
  logic               credit_ok;
  logic               pop;
  logic [CntW-1:0]    fifo_cnt;
  logic               fifo_empty;
  logic [WID_MEM:0]   fifo_head;
  logic [CntW:0]      committed;

  rb_fifo #(
    .Width(WID_MEM + 1),
    .Depth(RB_BUF_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (inflight_q),
    .wdata_i ({inflight_last_q, rdata_i}),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .count_o (fifo_cnt),
    .empty_o (fifo_empty)
  );

  assign m_valid_o = ~fifo_empty;
  assign m_data_o  = fifo_head[WID_MEM-1:0];
  assign m_last_o  = m_valid_o & fifo_head[WID_MEM];
  assign pop       = m_valid_o & m_ready_i;

  // A read may only go out if its word is guaranteed a slot when it lands.
  assign committed = {1'b0, fifo_cnt} + (CntW + 1)'(inflight_q);
  assign credit_ok = committed <= ((CntW + 1)'(RB_BUF_DEPTH - 1) + (CntW + 1)'(pop));

  always_comb begin
    state_d         = state_q;
    raddr_d         = raddr_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    chk_d           = chk_q;
    issue           = 1'b0;

    if (pop) begin
      chk_d = chk_q ^ m_data_o;
    end

    unique case (state_q)
      StIdle: begin
        // The done cycle is already idle, so it must explicitly refuse a start.
        if (start_i && !done_q) begin
          state_d = StStream;
          busy_d  = 1'b1;
          chk_d   = '0;
          raddr_d = '0;
        end
      end
      StStream: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (raddr_q == LastAddr) begin
            state_d = StFlush;
          end else begin
            raddr_d = raddr_q + ADDR_W'(1);
          end
        end
      end
      StFlush: begin
        if (pop && fifo_head[WID_MEM]) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase

    inflight_d      = issue;
    inflight_last_d = issue && (raddr_q == LastAddr);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= StIdle;
      raddr_q         <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      chk_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      raddr_q         <= raddr_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      chk_q           <= chk_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  assign raddr_o    = raddr_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign checksum_o = chk_q;

endmodule

// File: tb/tb_mem_readback_streamer.sv
// Self-checking bench: small 8-word sweeps with directed and random stalls,
// plus a full 4096-word sweep, all against a reference model of the stream.
module tb_mem_readback_streamer;

  localparam int D  = 8;
  localparam int DB = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        s_start = 1'b0;
  logic [11:0] s_raddr;
  logic [17:0] s_rdata;
  logic        s_valid;
  logic        s_ready = 1'b0;
  logic [17:0] s_data;
  logic        s_last;
  logic        s_busy;
  logic        s_done;
  logic [17:0] s_chk;

  logic        b_start = 1'b0;
  logic [11:0] b_raddr;
  logic [17:0] b_rdata;
  logic        b_valid;
  logic        b_ready = 1'b1;
  logic [17:0] b_data;
  logic        b_last;
  logic        b_busy;
  logic        b_done;
  logic [17:0] b_chk;

  logic [17:0] ram  [D];
  logic [17:0] bram [DB];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Registered-read memory models, one cycle of latency.
  always_ff @(posedge clk) begin
    s_rdata <= ram[s_raddr[2:0]];
    b_rdata <= bram[b_raddr];
  end

  mem_readback_streamer #(.WID_MEM(18), .DEPTH_MEM(D), .ADDR_W(12)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(s_start), .raddr_o(s_raddr), .rdata_i(s_rdata),
    .m_valid_o(s_valid), .m_ready_i(s_ready), .m_data_o(s_data), .m_last_o(s_last),
    .busy_o(s_busy), .done_o(s_done), .checksum_o(s_chk)
  );

  mem_readback_streamer #(.WID_MEM(18), .DEPTH_MEM(DB), .ADDR_W(12)) dut_big (
    .clk_i(clk), .rst_i(rst), .start_i(b_start), .raddr_o(b_raddr), .rdata_i(b_rdata),
    .m_valid_o(b_valid), .m_ready_i(b_ready), .m_data_o(b_data), .m_last_o(b_last),
    .busy_o(b_busy), .done_o(b_done), .checksum_o(b_chk)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // mode 0: ready always 1; mode 1: random ready; mode 2: ready low for 20 cycles.
  task automatic sweep(input int mode, input bit extra_starts, input int abort_after);
    int          idx;
    int          c;
    int          fin_cycle;
    int          dones;
    bit          finished;
    bit          prev_stall;
    bit          accept;
    logic [17:0] chk;
    logic [17:0] prev_data;
    logic        prev_last;
    logic [11:0] raddr_hold;
    idx = 0; c = 0; fin_cycle = -1; dones = 0; finished = 0; prev_stall = 0;
    chk = '0; prev_data = '0; prev_last = 1'b0; raddr_hold = '0;
    @(negedge clk);
    s_start = 1'b1;
    s_ready = (mode == 0);
    @(posedge clk);
    while (c < 300 && !(finished && c >= fin_cycle + 4)) begin
      @(negedge clk);
      c++;
      s_start = extra_starts && (c == 5 || c == 11);
      if (s_done === 1'b1) dones++;
      check("busy", s_busy, !(finished && c >= fin_cycle));
      check("done", s_done, (mode == 0) ? (c == 11) : (finished && c == fin_cycle));
      check("checksum", s_chk, chk);
      check("raddr_range", s_raddr <= 12'(D - 1), 1);
      if (mode == 0) check("valid_timing", s_valid, (c >= 3 && c <= 10));
      if (finished) check("valid_after_last", s_valid, 0);
      if (prev_stall) begin
        check("stall_valid", s_valid, 1);
        check("stall_data", s_data, prev_data);
        check("stall_last", s_last, prev_last);
      end
      if (s_valid === 1'b1 && !finished && idx < D) begin
        check("data", s_data, ram[idx]);
        check("last", s_last, (idx == D - 1));
      end
      if (mode == 2 && c == 8) raddr_hold = s_raddr;
      if (mode == 2 && c == 20) begin
        check("stall_raddr_frozen", s_raddr, raddr_hold);
        check("stall_reads_bounded", s_raddr <= 12'd4, 1);
        check("stall_first_word", s_data, ram[0]);
      end
      case (mode)
        0:       s_ready = 1'b1;
        1:       s_ready = 1'($urandom_range(0, 1));
        default: s_ready = (c > 20);
      endcase
      accept     = (s_valid === 1'b1) && s_ready && !finished && idx < D;
      prev_stall = (s_valid === 1'b1) && !s_ready && !finished;
      prev_data  = s_data;
      prev_last  = s_last;
      if (accept) begin
        chk = chk ^ ram[idx];
        idx++;
        if (idx == D) begin
          finished  = 1;
          fin_cycle = c + 1;
        end
        if (idx == abort_after) begin
          @(posedge clk);
          #2 rst = 1'b1;
          #1;
          check("abort_valid", s_valid, 0);
          check("abort_last", s_last, 0);
          check("abort_busy", s_busy, 0);
          check("abort_done", s_done, 0);
          check("abort_checksum", s_chk, 0);
          check("abort_raddr", s_raddr, 0);
          @(negedge clk);
          rst = 1'b0;
          s_ready = 1'b1;
          repeat (5) begin
            @(negedge clk);
            check("abort_no_done", s_done, 0);
            check("abort_idle", s_busy, 0);
            check("abort_no_valid", s_valid, 0);
          end
          return;
        end
      end
    end
    check("sweep_completed", finished, 1);
    check("single_done", dones, 1);
  endtask

  initial begin
    int          bidx;
    int          bc;
    int          bdone_c;
    logic [17:0] bxor;
    for (int i = 0; i < D; i++) ram[i] = 18'(i + 'h100);
    bxor = '0;
    for (int i = 0; i < DB; i++) begin
      bram[i] = 18'($urandom);
      bxor    = bxor ^ bram[i];
    end

    #1;
    check("rst_valid", s_valid, 0);
    check("rst_last", s_last, 0);
    check("rst_busy", s_busy, 0);
    check("rst_done", s_done, 0);
    check("rst_checksum", s_chk, 0);
    check("rst_raddr", s_raddr, 0);
    check("rst_big_valid", b_valid, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    sweep(0, 1'b0, -1);
    sweep(0, 1'b1, -1);
    for (int i = 0; i < D; i++) ram[i] = 18'($urandom);
    sweep(1, 1'b0, -1);
    sweep(1, 1'b0, -1);
    for (int i = 0; i < D; i++) ram[i] = 18'(i + 'h100);
    sweep(1, 1'b0, 3);
    sweep(0, 1'b0, -1);
    for (int i = 0; i < D; i++) ram[i] = 18'($urandom);
    sweep(2, 1'b0, -1);

    bidx = 0; bc = 0; bdone_c = -1;
    @(negedge clk);
    b_start = 1'b1;
    @(posedge clk);
    while (bc < DB + 100 && bdone_c < 0) begin
      @(negedge clk);
      bc++;
      b_start = 1'b0;
      if (b_valid === 1'b1) begin
        if (bidx < DB) begin
          check("big_data", b_data, bram[bidx]);
          check("big_last", b_last, (bidx == DB - 1));
        end else begin
          check("big_extra_beat", b_valid, 0);
        end
        bidx++;
      end
      if (b_done === 1'b1) begin
        bdone_c = bc;
        check("big_checksum", b_chk, bxor);
        check("big_busy_at_done", b_busy, 0);
      end
    end
    check("big_beats", bidx, DB);
    check("big_done_cycle", bdone_c, DB + 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
